// File: rtl/audio_pkg.sv
// Shared types and constants for the audio PWM output path.
package audio_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      RUN    = 2'd1,
      STARVE = 2'd2
   } state_t;

   typedef logic signed [15:0] sample_t;

   localparam int DEFAULT_SAMPLE_DIV = 100;

   // Two's complement to offset binary: flipping the sign bit maps -32768..32767 onto 0..65535.
   function automatic logic [15:0] to_offset(input sample_t s);
      return {~s[15], s[14:0]};
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Sample buffer between the playback stage and the modulator.
// A push is accepted when not full, or when full but a pop happens in the same cycle.
module audio_sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  sample_t                wdata,
   output sample_t                rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   sample_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == {(AW+1){1'b0}});
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage write port; contents are don't-care until pointed at.
   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
            2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/audio_pwm_out.sv
// Buffered sample-rate playback into a first-order sigma-delta 1-bit stream.
// Optional volume attenuation is enabled with `define AUDIO_PWM_VOLUME_EN.
module audio_pwm_out
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
   parameter int PREFILL    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  sample_t     sample_in,
   input  logic        sample_valid,
`ifdef AUDIO_PWM_VOLUME_EN
   input  logic [3:0]  volume,
`endif
   output logic        pwm_out,
   output logic        overflow,
   output logic [15:0] underrun_cnt,
   output logic        playing
);

   localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int OW = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0] tick_cnt;
   logic          tick;
   state_t        state;
   sample_t       cur_sample;
   sample_t       head;
   sample_t       scaled;
   logic [OW-1:0] occupancy;
   logic          full;
   logic          empty;
   logic          prefilled;
   logic          pop;
   logic          push;
   logic [16:0]   acc;
   logic [15:0]   u;

   assign tick      = (tick_cnt == CW'(SAMPLE_DIV - 1));
   assign prefilled = (occupancy >= OW'(PREFILL));
   assign push      = sample_valid && !rst;

   audio_sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (sample_in),
      .rdata (head),
      .count (occupancy),
      .full  (full),
      .empty (empty)
   );

   // Pop decision is taken on the registered occupancy, so a same-cycle push never counts.
   always_comb begin
      pop = 1'b0;
      if (tick) begin
         case (state)
            FILL:    pop = prefilled;
            STARVE:  pop = prefilled;
            RUN:     pop = !empty;
            default: pop = 1'b0;
         endcase
      end else begin
         pop = 1'b0;
      end
   end

   // Sample-period tick counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= {CW{1'b0}};
      end else if (tick) begin
         tick_cnt <= {CW{1'b0}};
      end else begin
         tick_cnt <= tick_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Sticky drop flag: a full FIFO only rejects a push when nothing pops that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (sample_valid && full && !pop) begin
         overflow <= 1'b1;
      end else begin
         overflow <= overflow;
      end
   end

   // Playback state machine with registered playing/underrun outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FILL;
         cur_sample   <= 16'sd0;
         underrun_cnt <= 16'd0;
         playing      <= 1'b0;
      end else if (tick) begin
         case (state)
            FILL, STARVE: begin
               if (prefilled) begin
                  cur_sample <= head;
                  state      <= RUN;
                  playing    <= 1'b1;
               end else if (state == STARVE && underrun_cnt != 16'hFFFF) begin
                  underrun_cnt <= underrun_cnt + 16'd1;
               end
            end
            RUN: begin
               if (!empty) begin
                  cur_sample <= head;
               end else begin
                  state   <= STARVE;
                  playing <= 1'b0;
                  if (underrun_cnt != 16'hFFFF) begin
                     underrun_cnt <= underrun_cnt + 16'd1;
                  end
               end
            end
            default: begin
               state   <= FILL;
               playing <= 1'b0;
            end
         endcase
      end
   end

`ifdef AUDIO_PWM_VOLUME_EN
   assign scaled = cur_sample >>> volume;
`else
   assign scaled = cur_sample;
`endif
   assign u = to_offset(scaled);

   // First-order sigma-delta: the carry out of the 16-bit accumulation is the output bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= 17'd0;
         pwm_out <= 1'b0;
      end else begin
         acc     <= {1'b0, acc[15:0]} + {1'b0, u};
         pwm_out <= acc[16];
      end
   end

endmodule

// File: doc/audio_pwm_out.md
AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, sample buffer entries (power of two, >=4).
REQ-002 SHALL have parameter SAMPLE_DIV, default 100, clk cycles per output sample period (4.4 MHz / 44 kHz).
REQ-003 SHALL have parameter PREFILL, default 4, FIFO occupancy required to start or resume playback (1..FIFO_DEPTH).
REQ-004 SHALL have port clk  input  1  system clock, 4.4 MHz.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sample_in  input  16  signed PCM sample from playback stage.
REQ-007 SHALL have port sample_valid  input  1  one-cycle strobe qualifying sample_in.
REQ-008 SHALL have port volume  input  4  attenuation shift (present only with AUDIO_PWM_VOLUME_EN).
REQ-009 SHALL have port pwm_out  output  1  1-bit sigma-delta audio stream.
REQ-010 SHALL have port overflow  output  1  sticky: a sample was dropped on a full FIFO.
REQ-011 SHALL have port underrun_cnt  output  16  count of starved sample ticks, saturating at 16'hFFFF.
REQ-012 SHALL have port playing  output  1  high while in state RUN.

Function
REQ-013 SHALL push sample_in when sample_valid=1 and FIFO not full; when full, SHALL drop the sample and set overflow.
REQ-014 SHALL run a tick counter 0..SAMPLE_DIV-1, wrapping; tick asserted for the single cycle in which counter = SAMPLE_DIV-1.
REQ-015 SHALL implement states FILL, RUN, STARVE; reset state FILL.
REQ-016 FILL: cur_sample = 0; on tick with occupancy >= PREFILL, SHALL pop the head into cur_sample and go to RUN.
REQ-017 RUN: on tick with FIFO non-empty, SHALL pop into cur_sample; on tick with FIFO empty, SHALL hold cur_sample, increment underrun_cnt, and go to STARVE.
REQ-018 STARVE: on tick with occupancy >= PREFILL, SHALL pop and go to RUN; otherwise SHALL hold cur_sample and increment underrun_cnt.
REQ-019 Occupancy decisions SHALL use registered occupancy; a sample pushed in the tick cycle is not counted for that tick.
REQ-020 Simultaneous push and pop SHALL both take effect, leaving occupancy unchanged; on a full FIFO, a push coinciding with a pop SHALL be accepted.
REQ-021 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 Modulator: u = cur_sample with MSB inverted (offset binary); 17-bit acc <= {1'b0, acc[15:0]} + u each cycle; pwm_out <= acc[16].
REQ-023 Long-run pwm_out density SHALL equal u/65536 (0x8000 -> 50%).
REQ-024 A popped sample SHALL first affect the accumulator in the cycle after the pop, and pwm_out one cycle later.

Reset
REQ-025 On rst=1 at a clk edge: FIFO empty, pointers 0, tick counter 0, state FILL, cur_sample 0, acc 0, pwm_out 0, overflow 0, underrun_cnt 0, playing 0.
REQ-026 Reset mid-playback SHALL discard all buffered samples; no push SHALL be accepted in a reset cycle.

Configuration
REQ-027 With AUDIO_PWM_VOLUME_EN defined, the volume port SHALL exist and the modulator SHALL use cur_sample >>> volume (arithmetic shift; 0 = unity, 15 = max attenuation).
REQ-028 Without AUDIO_PWM_VOLUME_EN, the volume port SHALL be absent and cur_sample SHALL be used unscaled.

Structure
REQ-029 Package audio_pkg SHALL hold the state enum (FILL/RUN/STARVE), the sample_t typedef (signed 16) and the default SAMPLE_DIV constant.
REQ-030 The FIFO SHALL be a separate sub-module, audio_sample_fifo (storage, pointers, occupancy, full/empty).

Verification
REQ-031 Push 3 samples, wait 5 ticks -> state stays FILL, pwm_out density 50%, underrun_cnt = 0.
REQ-032 Push 4 samples of 0x7FFF -> at the next tick, playing=1; over 1000 cycles pwm_out is high for at least 998 cycles.
REQ-033 Push 9 samples back-to-back with FIFO_DEPTH=8 and no tick -> overflow=1; the 9th sample is never played.
REQ-034 Push on the tick cycle with the FIFO full -> push accepted and occupancy stays 8.
REQ-035 Prefill 4 samples, stop input for 6 ticks -> the 4 samples play, then state STARVE with underrun_cnt = 2; refill 4 -> RUN at the next tick.
REQ-036 With AUDIO_PWM_VOLUME_EN, volume=1 and sample 0x7FFF -> density ~75% (u = 0xBFFF); assert rst mid-RUN -> all outputs return to their reset values on the next edge.
